// File: rtl/cu_trace_buf.sv
// Control-unit trace FIFO: captures {ts, op, func, ctrl} on change (or every cycle), freezes on Halt.
// FWFT read, zero added latency; full drops new entries or overwrites oldest. Optional CU_TRACE_DISPLAY_EN prints captures.
module cu_trace_buf #(
   parameter int CTRL_W      = 12,
   parameter int DEPTH       = 16,
   parameter int TS_W        = 16,
   parameter int WRAP        = 0,
   parameter int CAPTURE_ALL = 0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_clr,
   input  logic [5:0]                 i_op,
   input  logic [5:0]                 i_func,
   input  logic [CTRL_W-1:0]          i_ctrl,
   output logic                       o_rd_valid,
   input  logic                       i_rd_ready,
   output logic [TS_W+12+CTRL_W-1:0]  o_rd_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   output logic                       o_frozen
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int KW = 12 + CTRL_W;
   localparam int DW = TS_W + KW;

   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;
   logic [TS_W-1:0] r_ts;
   logic [KW-1:0]   r_prev_key;
   logic            r_have_prev, r_overflow, r_frozen;

   logic [KW-1:0]   w_key;
   logic [CW-1:0]   w_count_nxt;
   logic            w_halt, w_empty, w_full, w_capture, w_pop;
   logic            w_push, w_drop, w_overwrite, w_adv_rd;

   assign w_key   = {i_op, i_func, i_ctrl};
   assign w_halt  = i_ctrl[CTRL_W-1];
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   assign w_capture = i_en && !r_frozen &&
                      ((CAPTURE_ALL != 0) || !r_have_prev || (w_key != r_prev_key) || w_halt);
   assign w_pop       = i_rd_ready && !w_empty;
   // A pop on the same edge frees the slot, so a full buffer only loses data without one.
   assign w_drop      = w_capture && w_full && !w_pop && (WRAP == 0);
   assign w_overwrite = w_capture && w_full && !w_pop && (WRAP != 0);
   assign w_push      = w_capture && !w_drop;
   assign w_adv_rd    = w_pop || w_overwrite;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_adv_rd)
         w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_adv_rd)
         w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ts        <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_frozen    <= 1'b0;
         r_have_prev <= 1'b0;
         r_prev_key  <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
         if (i_clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_frozen    <= 1'b0;
            r_have_prev <= 1'b0;
         end else begin
            if (w_push)
               r_wptr <= r_wptr + AW'(1);
            if (w_adv_rd)
               r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            if (w_drop || w_overwrite)
               r_overflow <= 1'b1;
            // Key tracking follows captures even when the entry itself is dropped.
            if (w_capture) begin
               r_prev_key  <= w_key;
               r_have_prev <= 1'b1;
               if (w_halt)
                  r_frozen <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_clr && w_push)
         r_mem[r_wptr] <= {r_ts, w_key};
   end

   assign o_rd_valid = !w_empty;
   assign o_rd_data  = r_mem[r_rptr];
   assign o_count    = r_count;
   assign o_overflow = r_overflow;
   assign o_frozen   = r_frozen;

`ifdef CU_TRACE_DISPLAY_EN
   always @(posedge i_clk) begin
      if (!i_rst && !i_clr) begin
         if (w_push)
            $display("cu_trace_buf ts=%h op=%h func=%h halt=%h memtoreg=%h memwrite=%h beq=%h bne=%h aluop=%h alusrcb=%h regwrite=%h regdst=%h",
                     r_ts, i_op, i_func, i_ctrl[11], i_ctrl[10], i_ctrl[9], i_ctrl[8],
                     i_ctrl[7], i_ctrl[6:3], i_ctrl[2], i_ctrl[1], i_ctrl[0]);
         if (w_drop)
            $display("cu_trace_buf DROP new ts=%h op=%h func=%h ctrl=%h", r_ts, i_op, i_func, i_ctrl);
         if (w_overwrite)
            $display("cu_trace_buf DROP oldest entry=%h", r_mem[r_rptr]);
      end
   end
`endif
endmodule

// File: doc/cu_trace_buf.md
CU_TRACE_BUF -- requirements
Module: cu_trace_buf

Interface
REQ-001 Parameter CTRL_W, default 12, width of the packed control-signal vector (Halt, MemtoReg, MemWrite, Beq, Bne, AluOP[3:0], AluSrcB, RegWrite, RegDst).
REQ-002 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter TS_W, default 16, width of the timestamp counter.
REQ-004 Parameter WRAP, default 0; 1 = overwrite the oldest entry on full, 0 = drop the new entry on full.
REQ-005 Parameter CAPTURE_ALL, default 0; 1 = capture every enabled cycle, 0 = capture on change only.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 en  in  1  capture enable.
REQ-009 clr  in  1  synchronous flush of the trace buffer.
REQ-010 op  in  6  instruction opcode field.
REQ-011 func  in  6  instruction function field.
REQ-012 ctrl  in  CTRL_W  packed control-unit outputs; bit CTRL_W-1 is Halt.
REQ-013 rd_valid  out  1  buffer holds at least one entry.
REQ-014 rd_ready  in  1  consumer accepts the head entry.
REQ-015 rd_data  out  TS_W+12+CTRL_W  head entry {timestamp, op, func, ctrl}.
REQ-016 count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-017 overflow  out  1  sticky; one or more entries were dropped or overwritten.
REQ-018 frozen  out  1  capture stopped by Halt.

Function
REQ-019 The timestamp counter SHALL increment by 1 every cycle, wrap modulo 2^TS_W, and ignore clr.
REQ-020 The sample is {ts, op, func, ctrl}. The compare key is {op, func, ctrl}.
REQ-021 Capture SHALL occur when en=1, frozen=0, and any of these holds: CAPTURE_ALL=1; no previous capture exists; the key differs from the last captured key; ctrl[CTRL_W-1]=1.
REQ-022 A capture with ctrl[CTRL_W-1]=1 SHALL be stored and SHALL set frozen=1 from the next cycle.
REQ-023 The buffer SHALL be first-word-fall-through: rd_data SHALL equal the oldest entry whenever rd_valid=1.
REQ-024 An entry captured at edge N SHALL be visible on rd_valid/rd_data after edge N, with zero added latency.
REQ-025 A pop SHALL occur on an edge where rd_valid=1 and rd_ready=1; rd_ready with an empty buffer SHALL have no effect.
REQ-026 Push and pop on the same edge SHALL leave count unchanged, including at full, with no overflow.
REQ-027 Push at full without pop, WRAP=0: the entry SHALL be dropped and overflow set; the previous-key register SHALL still update.
REQ-028 Push at full without pop, WRAP=1: the oldest entry SHALL be discarded, the new entry written, count SHALL stay DEPTH, and overflow SHALL be set.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 clr SHALL empty the buffer and clear count, overflow, frozen and the previous-capture flag.
REQ-031 clr SHALL take priority over a capture or pop on the same edge.

Reset
REQ-032 rst SHALL take priority over clr and drive the following on the next edge: count=0, rd_valid=0, overflow=0, frozen=0, timestamp=0, pointers=0, previous-capture flag=0.
REQ-033 rst asserted mid-operation SHALL abandon all stored entries; entry contents need not be cleared.
REQ-034 rd_data SHALL be don't-care while rd_valid=0.

Configuration
REQ-035 With macro CU_TRACE_DISPLAY_EN defined, each accepted capture SHALL print one simulation line with the timestamp, op, func and every ctrl field in hex, and dropped entries SHALL print a "DROP" line.
REQ-036 Without CU_TRACE_DISPLAY_EN, the block SHALL contain no simulation-only constructs and be fully synthesizable with identical cycle behaviour.

Verification
REQ-037 Hold op=6'h23, func=0, ctrl constant for 10 cycles, en=1, CAPTURE_ALL=0 -> count=1, rd_data op=23.
REQ-038 Change ctrl every cycle for 20 cycles, DEPTH=16, WRAP=0, rd_ready=0 -> count=16, overflow=1, head holds the first sample.
REQ-039 Same stimulus as REQ-038 with WRAP=1 -> count=16, overflow=1, head holds the 5th sample, tail holds the 20th sample.
REQ-040 Buffer full, rd_ready=1 held while a new sample arrives each cycle -> count stays 16, overflow stays 0.
REQ-041 ctrl Halt bit=1 at ts=7 -> an entry with ts=7 is stored, frozen=1 from the next cycle, and later changes are ignored until clr; clr then gives count=0 and frozen=0.
REQ-042 rst pulsed with 5 entries stored -> after the next edge: count=0, rd_valid=0, overflow=0, and the timestamp restarts at 0.
